// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the interrupt/exception sequencer: FSM states, cause codes,
// mstatus bit positions and int_we strobe indices.
package int_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StWEpc   = 3'd1,
        StWCause = 3'd2,
        StWMst   = 3'd3,
        StWMsr   = 3'd4,
        StJump   = 3'd5
    } int_state_e;

    localparam int unsigned CauseEcall   = 11;
    localparam int unsigned CauseEbreak  = 3;
    localparam int unsigned CauseExtBase = 16;

    localparam int unsigned MstatusMie  = 3;
    localparam int unsigned MstatusMpie = 7;

    localparam int unsigned WeMepc    = 0;
    localparam int unsigned WeMcause  = 1;
    localparam int unsigned WeMstatus = 2;

    localparam logic [2:0] StrobeMepc    = 3'b001 << WeMepc;
    localparam logic [2:0] StrobeMcause  = 3'b001 << WeMcause;
    localparam logic [2:0] StrobeMstatus = 3'b001 << WeMstatus;

endpackage

// File: rtl/int_prio_enc.sv
// Lowest-index-wins priority encoder for the external interrupt lines.
module int_prio_enc #(
    parameter int unsigned W  = 8,
    parameter int unsigned IW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  req,
    output logic          valid,
    output logic [IW-1:0] idx
);

    assign valid = |req;

    // Scan from the top so the lowest set bit is the last to assign.
    always_comb begin
        idx = '0;
        for (int i = int'(W) - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt/exception sequencer: stalls the pipeline, writes mepc/mcause/mstatus one per cycle
// through the CSR int_* port, then redirects fetch to mtvec (trap) or mepc (mret).
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int unsigned DW    = 16,
    parameter int unsigned AW    = 16,
    parameter int unsigned INT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [INT_W-1:0] int_flag,
    input  logic             ID_ecall,
    input  logic             ID_ebreak,
    input  logic             ID_mret,
    input  logic [AW-1:0]    ID_pc,
    input  logic             EX_jump_flag,
    input  logic [AW-1:0]    EX_jump_addr,
    input  logic             EX_csr_we,
    input  logic [DW-1:0]    csr_mtvec,
    input  logic [DW-1:0]    csr_mepc,
    input  logic [DW-1:0]    csr_mstatus,
    input  logic             global_int_en,
    output logic [2:0]       int_we,
    output logic [DW-1:0]    int_mepc,
    output logic [DW-1:0]    int_mcause,
    output logic [DW-1:0]    int_mstatus,
    output logic             int_hold,
    output logic             int_jump_flag,
    output logic [AW-1:0]    int_jump_addr
);

    localparam int unsigned IW = (INT_W > 1) ? $clog2(INT_W) : 1;

    int_state_e    state_q;
    logic [DW-1:0] cause_q;

    logic          irq_valid;
    logic [IW-1:0] irq_idx;

    logic          sync_req;
    logic          async_req;
    logic          detect;
    logic [AW-1:0] async_epc;
    logic [DW-1:0] sync_cause;
    logic [DW-1:0] async_cause;
    logic [DW-1:0] trap_mstatus;
    logic [DW-1:0] mret_mstatus;

    int_prio_enc #(
        .W  (INT_W),
        .IW (IW)
    ) u_prio_enc (
        .req   (int_flag),
        .valid (irq_valid),
        .idx   (irq_idx)
    );

    assign sync_req  = ID_ecall | ID_ebreak;
    assign async_req = global_int_en & irq_valid;
    assign detect    = (state_q == StIdle) & (ID_mret | sync_req | async_req);
    assign int_hold  = (state_q != StIdle) | detect;

    // An interrupt taken while EX redirects must return to the branch target, not the ID slot.
    assign async_epc  = EX_jump_flag ? EX_jump_addr : ID_pc;
    assign sync_cause = ID_ecall ? DW'(CauseEcall) : DW'(CauseEbreak);

    always_comb begin
        async_cause         = DW'(CauseExtBase) + DW'(irq_idx);
        async_cause[DW-1]   = 1'b1;
        trap_mstatus        = csr_mstatus;
        trap_mstatus[MstatusMpie] = csr_mstatus[MstatusMie];
        trap_mstatus[MstatusMie]  = 1'b0;
        mret_mstatus        = csr_mstatus;
        mret_mstatus[MstatusMie]  = csr_mstatus[MstatusMpie];
        mret_mstatus[MstatusMpie] = 1'b1;
    end

    // Outputs are registered on entry to each state; a held state keeps repeating them
    // while EX owns the CSR write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            cause_q       <= '0;
            int_we        <= '0;
            int_mepc      <= '0;
            int_mcause    <= '0;
            int_mstatus   <= '0;
            int_jump_flag <= 1'b0;
            int_jump_addr <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    int_we        <= '0;
                    int_mepc      <= '0;
                    int_mcause    <= '0;
                    int_mstatus   <= '0;
                    int_jump_flag <= 1'b0;
                    int_jump_addr <= '0;
                    if (ID_mret) begin
                        state_q     <= StWMsr;
                        int_we      <= StrobeMstatus;
                        int_mstatus <= mret_mstatus;
                    end else if (sync_req) begin
                        state_q  <= StWEpc;
                        cause_q  <= sync_cause;
                        int_we   <= StrobeMepc;
                        int_mepc <= DW'(ID_pc);
                    end else if (async_req) begin
                        state_q  <= StWEpc;
                        cause_q  <= async_cause;
                        int_we   <= StrobeMepc;
                        int_mepc <= DW'(async_epc);
                    end
                end
                StWEpc: begin
                    if (!EX_csr_we) begin
                        state_q    <= StWCause;
                        int_we     <= StrobeMcause;
                        int_mepc   <= '0;
                        int_mcause <= cause_q;
                    end
                end
                StWCause: begin
                    if (!EX_csr_we) begin
                        state_q     <= StWMst;
                        int_we      <= StrobeMstatus;
                        int_mcause  <= '0;
                        int_mstatus <= trap_mstatus;
                    end
                end
                StWMst: begin
                    if (!EX_csr_we) begin
                        state_q       <= StJump;
                        int_we        <= '0;
                        int_mstatus   <= '0;
                        int_jump_flag <= 1'b1;
                        int_jump_addr <= AW'(csr_mtvec);
                    end
                end
                StWMsr: begin
                    if (!EX_csr_we) begin
                        state_q       <= StJump;
                        int_we        <= '0;
                        int_mstatus   <= '0;
                        int_jump_flag <= 1'b1;
                        int_jump_addr <= AW'(csr_mepc);
                    end
                end
                StJump: begin
                    state_q       <= StIdle;
                    int_jump_flag <= 1'b0;
                    int_jump_addr <= '0;
                end
                default: begin
                    state_q       <= StIdle;
                    int_we        <= '0;
                    int_jump_flag <= 1'b0;
                end
            endcase
        end
    end

endmodule
